// File: rtl/port_bus_pkg.sv
// Shared definitions for the port-expander bus: opcodes, scheduler FSM
// states and the layout of the header byte sent at the start of each frame.
package port_bus_pkg;

   localparam logic [1:0] OP_DIR   = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam int HDR_OP_MSB = 7;
   localparam int HDR_OP_LSB = 6;
   localparam int HDR_IDX_W  = 4;

   typedef enum logic [2:0] {
      ST_RST_PULSE = 3'd0,
      ST_IDLE      = 3'd1,
      ST_HDR       = 3'd2,
      ST_DATA      = 3'd3,
      ST_TURN      = 3'd4
   } state_e;

   function automatic logic [7:0] make_header(input logic [1:0] op,
                                              input logic [HDR_IDX_W-1:0] idx);
      logic [7:0] h;
      h = '0;
      h[HDR_OP_MSB:HDR_OP_LSB] = op;
      h[HDR_IDX_W-1:0] = idx;
      return h;
   endfunction

endpackage

// File: rtl/port_bus_scheduler_if.sv
// Request/acknowledge and expander-bus signals of the port bus scheduler.
// The slave modport is the scheduler; master is the port channels plus bus pins.
interface port_bus_scheduler_if #(
   parameter int NUM_PORTS = 10
);
   logic [NUM_PORTS-1:0]   req;
   logic [2*NUM_PORTS-1:0] req_op;
   logic [8*NUM_PORTS-1:0] req_wdata;
   logic [NUM_PORTS-1:0]   ack;
   logic [7:0]             rdata;
   logic                   busy;
   logic                   bus_rst;
   logic                   bus_oe;
   logic [7:0]             bus_dout;
   logic [7:0]             bus_din;

   modport master (
      output req, req_op, req_wdata, bus_din,
      input  ack, rdata, busy, bus_rst, bus_oe, bus_dout
   );

   modport slave (
      input  req, req_op, req_wdata, bus_din,
      output ack, rdata, busy, bus_rst, bus_oe, bus_dout
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search begins one past ptr and wraps
// modulo N; the first requester found wins.
module rr_arbiter #(
   parameter int N = 10,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          grant_valid,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] idx;

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      idx         = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((32'(ptr) + 32'(k)) % N);
         if (!grant_valid && req[idx]) begin
            grant_valid = 1'b1;
            grant_idx   = idx;
         end
      end
   end

endmodule

// File: rtl/port_bus_scheduler.sv
// Round-robin scheduler sharing the serial port-expander bus between port
// channels; runs header/data/turnaround frames and the expander reset pulse.
module port_bus_scheduler
   import port_bus_pkg::*;
#(
   parameter int NUM_PORTS  = 10,
   parameter int RST_CYCLES = 4
) (
   input logic clk,
   input logic rst_n,
   port_bus_scheduler_if.slave pb
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   state_e               state_q, state_nxt;
   logic [7:0]           cnt_q, cnt_nxt;
   logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_nxt;
   logic [IDX_W-1:0]     g_q, g_nxt;
   logic [1:0]           op_q, op_nxt;
   logic [7:0]           wd_q, wd_nxt;
   logic [NUM_PORTS-1:0] ack_q, ack_nxt;
   logic                 oe_q, oe_nxt;
   logic [7:0]           dout_q, dout_nxt;
   logic [7:0]           rdata_q;
   logic                 busy_q, bus_rst_q;

   logic                 grant_valid;
   logic [IDX_W-1:0]     grant_idx;
   logic [1:0]           op_arr [NUM_PORTS];
   logic [7:0]           wd_arr [NUM_PORTS];

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
      assign op_arr[i] = pb.req_op[2*i +: 2];
      assign wd_arr[i] = pb.req_wdata[8*i +: 8];
   end

   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .req         (pb.req),
      .ptr         (rr_ptr_q),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_comb begin
      state_nxt  = state_q;
      cnt_nxt    = cnt_q;
      rr_ptr_nxt = rr_ptr_q;
      g_nxt      = g_q;
      op_nxt     = op_q;
      wd_nxt     = wd_q;
      case (state_q)
         ST_RST_PULSE: begin
            cnt_nxt = cnt_q + 8'd1;
            if (cnt_q == 8'(RST_CYCLES - 1)) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (grant_valid) begin
               g_nxt      = grant_idx;
               op_nxt     = op_arr[grant_idx];
               wd_nxt     = wd_arr[grant_idx];
               rr_ptr_nxt = grant_idx;
               state_nxt  = ST_HDR;
            end
         end
         ST_HDR:  state_nxt = (op_q == OP_RSVD) ? ST_TURN : ST_DATA;
         ST_DATA: state_nxt = ST_TURN;
         ST_TURN: state_nxt = ST_IDLE;
         default: state_nxt = ST_RST_PULSE;
      endcase

      // Outputs are registered, so derive them from the state being entered.
      oe_nxt   = 1'b0;
      dout_nxt = '0;
      ack_nxt  = '0;
      case (state_nxt)
         ST_HDR: begin
            if (op_nxt != OP_RSVD) begin
               oe_nxt   = 1'b1;
               dout_nxt = make_header(op_nxt, HDR_IDX_W'(g_nxt));
            end
         end
         ST_DATA: begin
            if (op_nxt != OP_READ) begin
               oe_nxt   = 1'b1;
               dout_nxt = wd_nxt;
            end
         end
         ST_TURN: ack_nxt[g_nxt] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST_PULSE;
         cnt_q     <= '0;
         rr_ptr_q  <= IDX_W'(NUM_PORTS - 1);
         ack_q     <= '0;
         oe_q      <= 1'b0;
         dout_q    <= '0;
         rdata_q   <= '0;
         busy_q    <= 1'b1;
         bus_rst_q <= 1'b1;
      end else begin
         state_q   <= state_nxt;
         cnt_q     <= cnt_nxt;
         rr_ptr_q  <= rr_ptr_nxt;
         ack_q     <= ack_nxt;
         oe_q      <= oe_nxt;
         dout_q    <= dout_nxt;
         busy_q    <= (state_nxt != ST_IDLE);
         bus_rst_q <= (state_nxt == ST_RST_PULSE);
         if (state_q == ST_DATA && op_q == OP_READ) rdata_q <= pb.bus_din;
      end
   end

   // Frame context is only meaningful after a grant, so it carries no reset.
   always_ff @(posedge clk) begin
      g_q  <= g_nxt;
      op_q <= op_nxt;
      wd_q <= wd_nxt;
   end

   assign pb.ack      = ack_q;
   assign pb.rdata    = rdata_q;
   assign pb.busy     = busy_q;
   assign pb.bus_rst  = bus_rst_q;
   assign pb.bus_oe   = oe_q;
   assign pb.bus_dout = dout_q;

endmodule

// File: doc/port_bus_scheduler.md
Name: port_bus_scheduler

Overview:
- Round-robin scheduler that shares the 8-bit serial port-expander bus between NUM_PORTS port channels.
- Each channel posts a direction, read or write request. The block grants one request at a time and runs a fixed 3-cycle frame on the bus: header, data, turnaround.
- Returns read data and a per-port acknowledge.
- Also generates the expander reset pulse after system reset.

Parameters:
- NUM_PORTS, 10, number of requesting port channels; 2..16.
- RST_CYCLES, 4, number of cycles bus_rst is held high after reset release; 1..255.

Ports:
- clk  in  1  system clock; also the bus clock (forwarded outside this block).
- rst_n  in  1  reset, asynchronous assert, active-low.
- req  in  NUM_PORTS  per-port request level; held until ack.
- req_op  in  2*NUM_PORTS  per-port opcode in slice [2i+1:2i]: 00 dir, 01 read, 10 write, 11 reserved.
- req_wdata  in  8*NUM_PORTS  per-port write data or direction mask in slice [8i+7:8i].
- ack  out  NUM_PORTS  one-cycle completion pulse; at most one bit set.
- rdata  out  8  read data; valid in the ack cycle of a read and held until the next read.
- busy  out  1  high whenever state is not IDLE.
- bus_rst  out  1  expander reset.
- bus_oe  out  1  high when bus_dout must drive the shared data pins.
- bus_dout  out  8  bus output byte.
- bus_din  in  8  bus input byte, sampled on clk rising edge.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state=RST_PULSE, reset counter=0, rr_ptr=NUM_PORTS-1.
  - ack=0, rdata=0, bus_oe=0, bus_dout=0, bus_rst=1, busy=1.
- FSM states: RST_PULSE, IDLE, HDR, DATA, TURN. All outputs are registered.
- RST_PULSE:
  - bus_rst=1; counter increments each cycle.
  - After RST_CYCLES cycles, go to IDLE with bus_rst=0.
  - Requests are ignored during this state.
- IDLE, arbitration:
  - Search req starting at rr_ptr+1, wrapping modulo NUM_PORTS. The first set bit wins.
  - Latch winner index g, its op and its wdata. Set rr_ptr=g and go to HDR.
  - If no req bit is set, stay in IDLE.
- HDR, for op 00/01/10:
  - bus_oe=1, bus_dout={op[1:0],2'b00,g[3:0]}; next state DATA.
- HDR, for op 11:
  - No bus activity (bus_oe=0); go directly to TURN, so ack arrives one cycle after HDR.
- DATA:
  - dir or write: bus_oe=1, bus_dout=latched wdata.
  - read: bus_oe=0; on exit, rdata<=bus_din.
  - Next state TURN.
- TURN:
  - bus_oe=0, ack[g]=1 for this one cycle; next state IDLE.
- Latency:
  - Request visible in IDLE → ack 3 cycles later (IDLE→HDR→DATA→TURN).
  - Back-to-back grants occur every 4 cycles.
- Data capture:
  - Opcode and wdata are captured at grant. Later changes to them do not affect the frame in progress.
  - Deasserting req mid-frame does not abort the frame; ack still pulses.
- Fairness:
  - A port granted at cycle t cannot be granted again while any other port requests. This holds with all NUM_PORTS requesting continuously.
- Requesting ports must drop req in the cycle after ack.
  - If req is still high in IDLE, the port is treated as a new request under round-robin order.
- Reset mid-frame:
  - Frame is dropped and no ack is issued; sequence restarts at RST_PULSE.
- NUM_PORTS<16: header index bits above log2(NUM_PORTS) are 0.

Decomposition:
- Shared package port_bus_pkg:
  - opcode constants OP_DIR=2'b00, OP_READ=2'b01, OP_WRITE=2'b10, OP_RSVD=2'b11.
  - FSM state encoding.
  - header field layout (op bits [7:6], index bits [3:0]).
- One sub-module: rr_arbiter (parameter N).
  - Inputs: req, ptr. Outputs: grant_valid, grant_idx.
  - Purely combinational; reused by other bus masters.

Test Plan:
- Reset with RST_CYCLES=4 → bus_rst high for exactly 4 cycles after rst_n rises, then busy=0. Asserting rst_n low mid-frame → bus_oe=0 and bus_rst=1 immediately, with no ack.
- Port 3 write of 0xA5 → HDR bus_dout=0x83, then DATA bus_dout=0xA5 with bus_oe=1, then ack[3] exactly 3 cycles after the request was seen in IDLE.
- Port 1 read with bus_din=0x3C during DATA → HDR bus_dout=0x41, bus_oe=0 in DATA, rdata=0x3C in the ack[1] cycle and held afterwards.
- All 10 ports requesting continuously from reset → grant order 0,1,...,9,0; acks spaced every 4 cycles.
- Port 2 requests op 11 → no bus_oe, ack[2] one cycle after HDR. req_wdata changed after grant → bus_dout in DATA still shows the captured value.
- Ports 4 and 7 requesting with rr_ptr=5 → port 7 granted first, port 4 second; port 4's req dropped mid-frame → ack[4] still pulses.
